// File: rtl/pocq_sched_if.sv
// Handshake bundle between the POCQ scheduler (slave) and the queue/pipeline logic (master).
interface pocq_sched_if #(
    parameter int DEPTH = 16,
    parameter int IDXW  = $clog2(DEPTH)
);
    logic             alloc_en;
    logic             alloc_ready;
    logic [IDXW-1:0]  alloc_idx;
    logic [IDXW:0]    free_cnt;
    logic [DEPTH-1:0] wake_vec;
    logic             issue_valid;
    logic [IDXW-1:0]  issue_idx;
    logic             issue_ready;
    logic             retire_en;
    logic [IDXW-1:0]  retire_idx;
    logic             replay_en;
    logic [IDXW-1:0]  replay_idx;
    logic [DEPTH-1:0] sleep_vec;
    logic [DEPTH-1:0] busy_vec;

    modport master (
        output alloc_en, wake_vec, issue_ready, retire_en, retire_idx, replay_en, replay_idx,
        input  alloc_ready, alloc_idx, free_cnt, issue_valid, issue_idx, sleep_vec, busy_vec
    );

    modport slave (
        input  alloc_en, wake_vec, issue_ready, retire_en, retire_idx, replay_en, replay_idx,
        output alloc_ready, alloc_idx, free_cnt, issue_valid, issue_idx, sleep_vec, busy_vec
    );
endinterface

// File: rtl/pocq_sched.sv
// POCQ entry-state controller and round-robin issue scheduler for the HN-F main pipeline.
// Optional sleep timeout (forced wake after TIMEOUT cycles) enabled by POCQ_SCHED_TIMEOUT_EN.
module pocq_sched #(
    parameter int DEPTH   = 16,
    parameter int IDXW    = $clog2(DEPTH),
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    pocq_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_READY  = 2'd2,
        ST_INPIPE = 2'd3
    } ent_state_e;

    ent_state_e       state_r     [DEPTH];
    ent_state_e       state_nxt_s [DEPTH];
    logic             issue_valid_r;
    logic [IDXW-1:0]  issue_idx_r;
    logic [IDXW-1:0]  rr_ptr_r;
    logic             alloc_ready_s;
    logic [IDXW-1:0]  alloc_idx_s;
    logic [IDXW:0]    free_cnt_s;
    logic [DEPTH-1:0] sleep_s;
    logic [DEPTH-1:0] busy_s;
    logic             alloc_fire_s;
    logic             issue_fire_s;
    logic [DEPTH-1:0] tmo_s;
    logic [DEPTH-1:0] cand_s;
    logic [IDXW-1:0]  base_s;
    logic [IDXW-1:0]  scan_s;
    logic             pick_vld_s;
    logic [IDXW-1:0]  pick_idx_s;

    assign alloc_fire_s = bus.alloc_en & alloc_ready_s;
    assign issue_fire_s = issue_valid_r & bus.issue_ready;

`ifdef POCQ_SCHED_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] tmo_cnt_r [DEPTH];

    // Per-entry sleep age; held at zero outside SLEEP so it restarts on every entry to SLEEP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) tmo_cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (state_r[i] == ST_SLEEP) tmo_cnt_r[i] <= tmo_cnt_r[i] + CNTW'(1);
                else                        tmo_cnt_r[i] <= '0;
            end
        end
    end

    // Expiry fires one cycle early so READY is visible exactly TIMEOUT cycles after entering SLEEP.
    always_comb begin
        tmo_s = '0;
        for (int i = 0; i < DEPTH; i++)
            tmo_s[i] = (state_r[i] == ST_SLEEP) && (tmo_cnt_r[i] == CNTW'(TIMEOUT - 1));
    end
`else
    assign tmo_s = '0;
`endif

    // Entry state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) state_r[i] <= ST_FREE;
        end else begin
            for (int i = 0; i < DEPTH; i++) state_r[i] <= state_nxt_s[i];
        end
    end

    // Per-entry next state; retire outranks replay, and a replayed entry ignores a same-cycle wake.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_nxt_s[i] = state_r[i];
            case (state_r[i])
                ST_FREE: begin
                    if (alloc_fire_s && (alloc_idx_s == IDXW'(i))) state_nxt_s[i] = ST_SLEEP;
                    else                                           state_nxt_s[i] = ST_FREE;
                end
                ST_SLEEP: begin
                    if (bus.wake_vec[i] || tmo_s[i]) state_nxt_s[i] = ST_READY;
                    else                             state_nxt_s[i] = ST_SLEEP;
                end
                ST_READY: begin
                    if (issue_fire_s && (issue_idx_r == IDXW'(i))) state_nxt_s[i] = ST_INPIPE;
                    else                                           state_nxt_s[i] = ST_READY;
                end
                ST_INPIPE: begin
                    if (bus.retire_en && (bus.retire_idx == IDXW'(i)))      state_nxt_s[i] = ST_FREE;
                    else if (bus.replay_en && (bus.replay_idx == IDXW'(i))) state_nxt_s[i] = ST_SLEEP;
                    else                                                    state_nxt_s[i] = ST_INPIPE;
                end
                default: state_nxt_s[i] = ST_FREE;
            endcase
        end
    end

    // Allocation and status outputs decoded from current state; descending scan leaves the lowest FREE index.
    always_comb begin
        alloc_ready_s = 1'b0;
        alloc_idx_s   = '0;
        free_cnt_s    = '0;
        sleep_s       = '0;
        busy_s        = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_r[i] == ST_FREE) begin
                alloc_ready_s = 1'b1;
                alloc_idx_s   = IDXW'(i);
                free_cnt_s    = free_cnt_s + (IDXW + 1)'(1);
            end else begin
                busy_s[i] = 1'b1;
            end
            sleep_s[i] = (state_r[i] == ST_SLEEP);
        end
    end

    // Round-robin pick over READY entries, starting after the last grant; the entry just accepted is excluded.
    always_comb begin
        cand_s     = '0;
        scan_s     = '0;
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) cand_s[i] = (state_r[i] == ST_READY);
        if (issue_fire_s) begin
            cand_s[issue_idx_r] = 1'b0;
            base_s              = issue_idx_r;
        end else begin
            base_s = rr_ptr_r;
        end
        for (int k = 1; k <= DEPTH; k++) begin
            scan_s     = base_s + IDXW'(k);
            pick_idx_s = (!pick_vld_s && cand_s[scan_s]) ? scan_s : pick_idx_s;
            pick_vld_s = pick_vld_s | cand_s[scan_s];
        end
    end

    // Registered offer and round-robin pointer; an unaccepted offer is held without re-arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_valid_r <= 1'b0;
            issue_idx_r   <= '0;
            rr_ptr_r      <= {IDXW{1'b1}};
        end else begin
            if (issue_fire_s) rr_ptr_r <= issue_idx_r;
            else              rr_ptr_r <= rr_ptr_r;
            if (issue_valid_r && !bus.issue_ready) begin
                issue_valid_r <= issue_valid_r;
                issue_idx_r   <= issue_idx_r;
            end else begin
                issue_valid_r <= pick_vld_s;
                issue_idx_r   <= pick_idx_s;
            end
        end
    end

    assign bus.alloc_ready = alloc_ready_s;
    assign bus.alloc_idx   = alloc_idx_s;
    assign bus.free_cnt    = free_cnt_s;
    assign bus.sleep_vec   = sleep_s;
    assign bus.busy_vec    = busy_s;
    assign bus.issue_valid = issue_valid_r;
    assign bus.issue_idx   = issue_idx_r;
endmodule

// File: tb/tb_pocq_sched.sv
// Directed self-checking bench for pocq_sched (DEPTH=16, TIMEOUT=8).
module tb_pocq_sched;
    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    pocq_sched_if #(.DEPTH(16)) bus ();

    pocq_sched #(.DEPTH(16), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alloc_en    = 1'b0;
        bus.wake_vec    = 16'h0000;
        bus.issue_ready = 1'b0;
        bus.retire_en   = 1'b0;
        bus.retire_idx  = 4'd0;
        bus.replay_en   = 1'b0;
        bus.replay_idx  = 4'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #12;
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL rst_issue_valid got %0h want 0", bus.issue_valid); end
        n_vec++; if (bus.issue_idx !== 4'd0) begin n_err++; $display("FAIL rst_issue_idx got %0h want 0", bus.issue_idx); end
        n_vec++; if (bus.alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ready got %0h want 1", bus.alloc_ready); end
        n_vec++; if (bus.alloc_idx !== 4'd0) begin n_err++; $display("FAIL rst_alloc_idx got %0h want 0", bus.alloc_idx); end
        n_vec++; if (bus.free_cnt !== 5'd16) begin n_err++; $display("FAIL rst_free_cnt got %0d want 16", bus.free_cnt); end
        n_vec++; if (bus.sleep_vec !== 16'h0000 || bus.busy_vec !== 16'h0000) begin n_err++; $display("FAIL rst_vecs got sleep %0h busy %0h want 0 0", bus.sleep_vec, bus.busy_vec); end
        @(negedge clock);
        reset = 1'b1;
        // Build a pending offer, then pull reset asynchronously mid-cycle.
        bus.alloc_en = 1'b1;
        step(); step();
        bus.alloc_en = 1'b0;
        bus.wake_vec = 16'h0003;
        step();
        bus.wake_vec = 16'h0000;
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd0) begin n_err++; $display("FAIL pre_mid_rst_offer got v%0h idx %0d want v1 idx 0", bus.issue_valid, bus.issue_idx); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (bus.issue_valid !== 1'b0 || bus.busy_vec !== 16'h0000 || bus.free_cnt !== 5'd16) begin
            n_err++; $display("FAIL mid_rst got v%0h busy %0h free %0d want 0 0 16", bus.issue_valid, bus.busy_vec, bus.free_cnt);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_alloc();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (bus.alloc_idx !== 4'(k) || bus.free_cnt !== 5'(16 - k)) begin
                n_err++; $display("FAIL alloc_seq got idx %0d cnt %0d want idx %0d cnt %0d", bus.alloc_idx, bus.free_cnt, k, 16 - k);
            end
            bus.alloc_en = 1'b1;
            step();
        end
        bus.alloc_en = 1'b0;
        n_vec++; if (bus.free_cnt !== 5'd13) begin n_err++; $display("FAIL alloc_free_cnt got %0d want 13", bus.free_cnt); end
        n_vec++; if (bus.sleep_vec !== 16'h0007) begin n_err++; $display("FAIL alloc_sleep got %0h want 0007", bus.sleep_vec); end
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL alloc_no_issue got %0h want 0", bus.issue_valid); end
    endtask

    task automatic test_wake_issue();
        bus.wake_vec    = 16'h0005;
        bus.issue_ready = 1'b1;
        step();
        bus.wake_vec = 16'h0000;
        n_vec++; if (bus.issue_valid !== 1'b0 || bus.sleep_vec !== 16'h0002) begin n_err++; $display("FAIL wake_lat got v%0h sleep %0h want v0 sleep 0002", bus.issue_valid, bus.sleep_vec); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd0) begin n_err++; $display("FAIL b2b_first got v%0h idx %0d want v1 idx 0", bus.issue_valid, bus.issue_idx); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd2) begin n_err++; $display("FAIL b2b_second got v%0h idx %0d want v1 idx 2", bus.issue_valid, bus.issue_idx); end
        n_vec++; if (bus.busy_vec !== 16'h0007) begin n_err++; $display("FAIL b2b_busy got %0h want 0007", bus.busy_vec); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %0h want 0", bus.issue_valid); end
        bus.issue_ready = 1'b0;
    endtask

    task automatic test_rr_hold();
        do_reset();
        bus.alloc_en = 1'b1;
        repeat (6) step();
        bus.alloc_en = 1'b0;
        bus.wake_vec = 16'h002A;
        step();
        bus.wake_vec = 16'h0000;
        step();
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd1) begin n_err++; $display("FAIL rr_hold c%0d got v%0h idx %0d want v1 idx 1", c, bus.issue_valid, bus.issue_idx); end
            step();
        end
        bus.issue_ready = 1'b1;
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd3) begin n_err++; $display("FAIL rr_next3 got v%0h idx %0d want v1 idx 3", bus.issue_valid, bus.issue_idx); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd5) begin n_err++; $display("FAIL rr_next5 got v%0h idx %0d want v1 idx 5", bus.issue_valid, bus.issue_idx); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL rr_drain got %0h want 0", bus.issue_valid); end
        bus.issue_ready = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        bus.alloc_en = 1'b1;
        repeat (16) step();
        n_vec++; if (bus.alloc_ready !== 1'b0 || bus.free_cnt !== 5'd0 || bus.alloc_idx !== 4'd0) begin
            n_err++; $display("FAIL full got rdy %0h cnt %0d idx %0d want 0 0 0", bus.alloc_ready, bus.free_cnt, bus.alloc_idx);
        end
        step();
        bus.alloc_en = 1'b0;
        n_vec++; if (bus.sleep_vec !== 16'hFFFF || bus.free_cnt !== 5'd0) begin n_err++; $display("FAIL full_extra got sleep %0h cnt %0d want FFFF 0", bus.sleep_vec, bus.free_cnt); end
        bus.wake_vec    = 16'h0080;
        bus.issue_ready = 1'b1;
        step();
        bus.wake_vec = 16'h0000;
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd7) begin n_err++; $display("FAIL fill_issue7 got v%0h idx %0d want v1 idx 7", bus.issue_valid, bus.issue_idx); end
        step();
        bus.issue_ready = 1'b0;
        bus.retire_en   = 1'b1;
        bus.retire_idx  = 4'd7;
        n_vec++; if (bus.alloc_ready !== 1'b0) begin n_err++; $display("FAIL retire_same_cycle got rdy %0h want 0", bus.alloc_ready); end
        step();
        bus.retire_en = 1'b0;
        n_vec++; if (bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 4'd7 || bus.free_cnt !== 5'd1) begin
            n_err++; $display("FAIL retire7 got rdy %0h idx %0d cnt %0d want 1 7 1", bus.alloc_ready, bus.alloc_idx, bus.free_cnt);
        end
        bus.alloc_en = 1'b1;
        bus.wake_vec = 16'h0080;
        step();
        bus.alloc_en = 1'b0;
        bus.wake_vec = 16'h0000;
        n_vec++; if (bus.sleep_vec !== 16'hFFFF || bus.free_cnt !== 5'd0) begin n_err++; $display("FAIL alloc_wake got sleep %0h cnt %0d want FFFF 0", bus.sleep_vec, bus.free_cnt); end
    endtask

    task automatic test_simul();
        bus.wake_vec    = 16'h0050;
        bus.issue_ready = 1'b1;
        step();
        bus.wake_vec = 16'h0000;
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd4) begin n_err++; $display("FAIL sim_issue4 got v%0h idx %0d want v1 idx 4", bus.issue_valid, bus.issue_idx); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd6) begin n_err++; $display("FAIL sim_issue6 got v%0h idx %0d want v1 idx 6", bus.issue_valid, bus.issue_idx); end
        step();
        bus.issue_ready = 1'b0;
        bus.retire_en   = 1'b1;
        bus.retire_idx  = 4'd4;
        bus.replay_en   = 1'b1;
        bus.replay_idx  = 4'd4;
        step();
        bus.retire_en = 1'b0;
        bus.replay_en = 1'b0;
        n_vec++; if (bus.busy_vec !== 16'hFFEF || bus.free_cnt !== 5'd1 || bus.alloc_idx !== 4'd4) begin
            n_err++; $display("FAIL retire_wins got busy %0h cnt %0d idx %0d want FFEF 1 4", bus.busy_vec, bus.free_cnt, bus.alloc_idx);
        end
        bus.replay_en  = 1'b1;
        bus.replay_idx = 4'd6;
        bus.wake_vec   = 16'h0040;
        step();
        bus.replay_en = 1'b0;
        bus.wake_vec  = 16'h0000;
        n_vec++; if (bus.sleep_vec !== 16'hFFEF) begin n_err++; $display("FAIL replay_wake got sleep %0h want FFEF", bus.sleep_vec); end
        step();
        n_vec++; if (bus.sleep_vec[6] !== 1'b1 || bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL replay_stays got sleep6 %0h v%0h want 1 0", bus.sleep_vec[6], bus.issue_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.alloc_en = 1'b1;
        step();
        bus.alloc_en = 1'b0;
        n_vec++; if (bus.sleep_vec !== 16'h0001) begin n_err++; $display("FAIL tmo_enter got %0h want 0001", bus.sleep_vec); end
        repeat (7) step();
        n_vec++; if (bus.sleep_vec !== 16'h0001 || bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL tmo_early got sleep %0h v%0h want 0001 0", bus.sleep_vec, bus.issue_valid); end
        step();
`ifdef POCQ_SCHED_TIMEOUT_EN
        n_vec++; if (bus.sleep_vec !== 16'h0000 || bus.busy_vec !== 16'h0001) begin n_err++; $display("FAIL tmo_wake got sleep %0h busy %0h want 0 0001", bus.sleep_vec, bus.busy_vec); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd0) begin n_err++; $display("FAIL tmo_issue got v%0h idx %0d want v1 idx 0", bus.issue_valid, bus.issue_idx); end
`else
        n_vec++; if (bus.sleep_vec !== 16'h0001) begin n_err++; $display("FAIL no_tmo_sleep got %0h want 0001", bus.sleep_vec); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0 || bus.sleep_vec !== 16'h0001) begin n_err++; $display("FAIL no_tmo_issue got v%0h sleep %0h want 0 0001", bus.issue_valid, bus.sleep_vec); end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_alloc();
        test_wake_issue();
        test_rr_hold();
        test_fill();
        test_simul();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
